// File: rtl/conv_enc_pkg.sv
// Shared constants, rate encodings and puncture masks for the 802.11a K=7 convolutional encoder.
// Puncturing support is compiled in only when CONV_ENCODER_PUNCTURE_EN is defined.
`timescale 1ns/1ps
package conv_enc_pkg;

    localparam logic [6:0] G0_DEFAULT = 7'b1011011;  // 133 octal
    localparam logic [6:0] G1_DEFAULT = 7'b1111001;  // 171 octal

    localparam logic [1:0] RATE_1_2 = 2'b00;
    localparam logic [1:0] RATE_2_3 = 2'b01;
    localparam logic [1:0] RATE_3_4 = 2'b10;

    // Per-phase {keep_a, keep_b}; entry index is the phase.
    localparam logic [1:0][1:0] MASK_2_3 = {2'b10, 2'b11};
    localparam logic [3:0][1:0] MASK_3_4 = {2'b11, 2'b01, 2'b10, 2'b11};

    // bits[1] leaves the output buffer first.
    typedef struct packed {
        logic [1:0] cnt;
        logic [1:0] bits;
    } emit_t;

    function automatic emit_t puncture(input logic a, input logic b, input logic [1:0] keep);
        emit_t e;
        case (keep)
            2'b10:   e = '{cnt: 2'd1, bits: {a, 1'b0}};
            2'b01:   e = '{cnt: 2'd1, bits: {b, 1'b0}};
            default: e = '{cnt: 2'd2, bits: {a, b}};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/conv_puncturer.sv
// Phase counter and latched rate; maps each coded (A,B) pair to the 1 or 2 bits actually sent.
// Only built when CONV_ENCODER_PUNCTURE_EN is defined.
`timescale 1ns/1ps
`ifdef CONV_ENCODER_PUNCTURE_EN
module conv_puncturer
    import conv_enc_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic       FrameStart,
    input  logic [1:0] RateSel,
    input  logic       accept,
    input  logic       bit_a,
    input  logic       bit_b,
    output emit_t      emit
);

    logic [1:0] rate_q;
    logic [1:0] phase_q;
    logic [1:0] rate_eff;
    logic [1:0] phase_eff;
    logic [1:0] phase_last;
    logic [1:0] phase_nxt;
    logic [1:0] keep;

    // A bit accepted together with FrameStart is phase 0 of the newly selected rate.
    always_comb begin
        rate_eff   = FrameStart ? RateSel : rate_q;
        phase_eff  = FrameStart ? 2'd0 : phase_q;
        keep       = 2'b11;
        phase_last = 2'd0;
        case (rate_eff)
            RATE_2_3: begin
                keep       = MASK_2_3[phase_eff[0]];
                phase_last = 2'd1;
            end
            RATE_3_4: begin
                keep       = MASK_3_4[phase_eff];
                phase_last = 2'd2;
            end
            default: ;
        endcase
        phase_nxt = (phase_eff == phase_last) ? 2'd0 : phase_eff + 2'd1;
        emit      = puncture(bit_a, bit_b, keep);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            rate_q  <= RATE_1_2;
            phase_q <= 2'd0;
        end else begin
            if (FrameStart)
                rate_q <= RateSel;
            if (accept)
                phase_q <= phase_nxt;
            else if (FrameStart)
                phase_q <= 2'd0;
        end
    end

endmodule
`endif

// File: rtl/conv_encoder.sv
// 802.11a K=7 rate-1/2 convolutional encoder with serial valid/ready in and out.
// Define CONV_ENCODER_PUNCTURE_EN to add puncturing to rates 2/3 and 3/4.
`timescale 1ns/1ps
module conv_encoder
    import conv_enc_pkg::*;
#(
    parameter logic [6:0] G0 = G0_DEFAULT,
    parameter logic [6:0] G1 = G1_DEFAULT
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       FrameStart,
    input  logic [1:0] RateSel,
    input  logic       InValid,
    input  logic       InBit,
    output logic       InReady,
    output logic       OutValid,
    output logic       OutBit,
    input  logic       OutReady
);

    logic [5:0] sr_q;
    logic [5:0] sr_eff;
    logic [6:0] window;
    logic [1:0] cnt_q;
    logic [1:0] buf_q;
    logic       bit_a;
    logic       bit_b;
    logic       accept;
    logic       pop;
    emit_t      emit;

    always_comb begin
        // NOTE: every output of this block is assigned on every path, so no latch is inferred.
        sr_eff   = FrameStart ? 6'd0 : sr_q;
        window   = {InBit, sr_eff[0], sr_eff[1], sr_eff[2], sr_eff[3], sr_eff[4], sr_eff[5]};
        bit_a    = ^(window & G0);
        bit_b    = ^(window & G1);
        // Input is taken only when the buffer will be empty after this cycle's transfer.
        InReady  = ~Reset & ((cnt_q == 2'd0) | ((cnt_q == 2'd1) & OutReady));
        OutValid = ~Reset & (cnt_q != 2'd0);
        OutBit   = ~Reset & buf_q[1];
        accept   = InValid & InReady;
        pop      = OutValid & OutReady;
    end

`ifdef CONV_ENCODER_PUNCTURE_EN
    conv_puncturer u_puncturer (
        .Clock      (Clock),
        .Reset      (Reset),
        .FrameStart (FrameStart),
        .RateSel    (RateSel),
        .accept     (accept),
        .bit_a      (bit_a),
        .bit_b      (bit_b),
        .emit       (emit)
    );
`else
    logic unused_rate_sel;
    assign unused_rate_sel = ^RateSel;
    assign emit = '{cnt: 2'd2, bits: {bit_a, bit_b}};
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sr_q  <= 6'd0;
            cnt_q <= 2'd0;
            // NOTE: buffer data is reset too (not just the count) so OutBit reads 0 when idle.
            buf_q <= 2'd0;
        end else begin
            // NOTE: non-blocking updates keep every register reading pre-edge values.
            if (accept)
                sr_q <= {sr_eff[4:0], InBit};
            else if (FrameStart)
                sr_q <= 6'd0;

            if (accept) begin
                cnt_q <= emit.cnt;
                buf_q <= emit.bits;
            end else if (FrameStart) begin
                cnt_q <= 2'd0;
                buf_q <= 2'd0;
            end else if (pop) begin
                cnt_q <= cnt_q - 2'd1;
                buf_q <= {buf_q[0], 1'b0};
            end
        end
    end

endmodule
